contador_universal_param: RTL

- Parametrised successor to the 4-bit mode counter: WIDTH-bit universal counter with a programmable modulus (LIMIT), a wrap or saturate policy, and a cascade carry-in (CI) / terminal-count (TC) pair.
- N stages chained TC→CI form a wider counter without per-stage RCO gymnastics.
- Sits wherever the design needs a loadable up/down/step-3 counter. Drop-in for the 4-bit and 16-bit counter tests with WIDTH=4/16 and LIMIT=all-ones.

---
 rtl/contador_universal_param.sv | 100 ++++++++++
 1 files changed

// File: rtl/contador_universal_param.sv
// Universal WIDTH-bit counter: up / down-1 / down-3 / load within 0..LIMIT,
// wrap or saturate at the boundary, cascadable through CI -> TC.
module contador_universal_param #(
  parameter int WIDTH    = 16,
  parameter int SATURATE = 0
) (
  input  logic             CLK,
  input  logic             RST_L,
  input  logic             ENB,
  input  logic             CI,
  input  logic [1:0]       MODO,
  input  logic [WIDTH-1:0] D,
  input  logic [WIDTH-1:0] LIMIT,
  output logic [WIDTH-1:0] Q,
  output logic             RCO,
  output logic             TC
);

  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
  localparam logic [WIDTH-1:0] THREE = WIDTH'(3);
  localparam logic [WIDTH:0]   TWO_X = (WIDTH+1)'(2);
  localparam bit               SAT   = (SATURATE != 0);

  logic [WIDTH-1:0] r_q;
  logic             r_rco;

  logic             w_hi;
  logic             w_at;
  logic             w_zero;
  logic             w_lt3;
  logic             w_small;
  logic             w_bnd;
  logic [WIDTH-1:0] w_wr3;
  logic [WIDTH-1:0] w_nq;
  logic             w_rco;

  assign w_hi    = r_q > LIMIT;
  assign w_at    = r_q >= LIMIT;
  assign w_zero  = r_q == '0;
  assign w_lt3   = r_q < THREE;
  // LIMIT+Q < 2 means the down-3 wrap target would fall below zero
  assign w_small = ({1'b0, LIMIT} + {1'b0, r_q}) < TWO_X;
  assign w_wr3   = w_small ? LIMIT : (LIMIT + r_q + ONE - THREE);

  always_comb begin
    w_bnd = 1'b0;
    unique case (MODO)
      2'b00:   w_bnd = w_at;
      2'b01:   w_bnd = w_zero;
      2'b10:   w_bnd = w_lt3 & ~w_hi;
      default: w_bnd = 1'b0;
    endcase
  end

  assign TC = ENB & CI & w_bnd;

  always_comb begin
    w_nq  = r_q;
    w_rco = 1'b0;
    if (ENB) begin
      if (MODO == 2'b11) begin
        w_nq = (D > LIMIT) ? LIMIT : D;
      end else if (CI) begin
        w_rco = w_bnd;
        unique case (MODO)
          2'b00: begin
            if (w_at) w_nq = SAT ? LIMIT : '0;
            else      w_nq = r_q + ONE;
          end
          2'b01: begin
            unique case (1'b1)
              w_hi:    w_nq = LIMIT;
              w_zero:  w_nq = SAT ? '0 : LIMIT;
              default: w_nq = r_q - ONE;
            endcase
          end
          default: begin
            if (w_hi)       w_nq = LIMIT;
            else if (w_lt3) w_nq = SAT ? '0 : w_wr3;
            else            w_nq = r_q - THREE;
          end
        endcase
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_L) begin
    if (!RST_L) begin
      r_q   <= '0;
      r_rco <= 1'b0;
    end else begin
      r_q   <= w_nq;
      r_rco <= w_rco;
    end
  end

  assign Q   = r_q;
  assign RCO = r_rco;

endmodule
